// File: rtl/pixel_readout_pkg.sv
// Shared definitions for the pixel readout decoder.
//   DEFAULT_BIT_DEPTH : pixel word width, shared with the array counter
//   MAX_BIT_DEPTH     : widest word the decode helper handles
//   frame_state_t     : frame FSM states
//   gray_to_bin()     : gray-to-binary decode helper
package pixel_readout_pkg;

    localparam int DEFAULT_BIT_DEPTH = 10;
    localparam int MAX_BIT_DEPTH     = 32;

    typedef enum logic [1:0] {
        FRAME_IDLE   = 2'd0,
        FRAME_ACTIVE = 2'd1,
        FRAME_DRAIN  = 2'd2
    } frame_state_t;

    // Narrower words are decoded by zero-extending them: leading zero gray
    // bits decode to leading zero binary bits, so truncating the result
    // back to the original width gives the exact decode.
    function automatic logic [MAX_BIT_DEPTH-1:0] gray_to_bin(
        input logic [MAX_BIT_DEPTH-1:0] gray
    );
        logic [MAX_BIT_DEPTH-1:0] bin;
        bin[MAX_BIT_DEPTH-1] = gray[MAX_BIT_DEPTH-1];
        for (int i = MAX_BIT_DEPTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/pixel_readout_fifo.sv
// Synchronous FIFO holding decoded pixel entries.
//   clk, rst          : clock and synchronous active-high reset
//   push, push_data   : write strobe and entry
//   pop, pop_data     : read strobe and head entry (head is always visible)
//   full, empty       : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_readout_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage; cleared on reset so the head reads zero when empty after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pixel_readout_decoder.sv
// Gray-to-binary pixel readout decoder with frame tracking.
//   readout_clock, readout_reset : clock, synchronous active-high reset
//   gray_data/valid/ready        : gray-coded input handshake
//   pixel_data/index/last/valid  : decoded output (FIFO head)
//   pixel_ready                  : consumer accept
//   frame_done                   : pulses when a frame's last word is popped
// Only one frame is ever buffered: input stalls once the last word of a
// frame is accepted until that word leaves.
module pixel_readout_decoder
    import pixel_readout_pkg::*;
#(
    parameter int BIT_DEPTH        = DEFAULT_BIT_DEPTH,
    parameter int PIXELS_PER_FRAME = 4,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                readout_clock,
    input  logic                                readout_reset,
    input  logic [BIT_DEPTH-1:0]                gray_data,
    input  logic                                gray_valid,
    output logic                                gray_ready,
    output logic [BIT_DEPTH-1:0]                pixel_data,
    output logic [$clog2(PIXELS_PER_FRAME)-1:0] pixel_index,
    output logic                                pixel_last,
    output logic                                pixel_valid,
    input  logic                                pixel_ready,
    output logic                                frame_done
);

    localparam int INDEX_W = $clog2(PIXELS_PER_FRAME);
    localparam int ENTRY_W = INDEX_W + BIT_DEPTH;
    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(PIXELS_PER_FRAME - 1);

    frame_state_t        state_r;
    frame_state_t        state_next_s;
    logic [INDEX_W-1:0]  in_index_r;
    logic [BIT_DEPTH-1:0] decoded_s;
    logic [ENTRY_W-1:0]  head_s;
    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                empty_s;
    logic                head_last_s;

    assign decoded_s   = BIT_DEPTH'(gray_to_bin(MAX_BIT_DEPTH'(gray_data)));
    assign gray_ready  = (state_r != FRAME_DRAIN) && !full_s;
    assign push_s      = gray_valid && gray_ready;
    assign pixel_valid = !empty_s;
    assign pop_s       = pixel_valid && pixel_ready;

    assign {pixel_index, pixel_data} = head_s;
    assign head_last_s = (pixel_index == LAST_INDEX);
    assign pixel_last  = pixel_valid && head_last_s;
    // Reset wins over a simultaneous pop, so no completion is reported then.
    assign frame_done  = (state_r == FRAME_DRAIN) && pop_s && head_last_s && !readout_reset;

    pixel_readout_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (readout_clock),
        .rst       (readout_reset),
        .push      (push_s),
        .push_data ({in_index_r, decoded_s}),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Input pixel index: counts accepted words, wrapping at frame end.
    always_ff @(posedge readout_clock) begin
        if (readout_reset) begin
            in_index_r <= {INDEX_W{1'b0}};
        end else if (push_s) begin
            in_index_r <= (in_index_r == LAST_INDEX) ? {INDEX_W{1'b0}}
                                                     : in_index_r + INDEX_W'(1);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge readout_clock) begin
        if (readout_reset) begin
            state_r <= FRAME_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FRAME_IDLE: begin
                if (push_s) begin
                    state_next_s = (in_index_r == LAST_INDEX) ? FRAME_DRAIN : FRAME_ACTIVE;
                end else begin
                    state_next_s = FRAME_IDLE;
                end
            end
            FRAME_ACTIVE: begin
                if (push_s && (in_index_r == LAST_INDEX)) begin
                    state_next_s = FRAME_DRAIN;
                end else begin
                    state_next_s = FRAME_ACTIVE;
                end
            end
            FRAME_DRAIN: begin
                if (pop_s && head_last_s) begin
                    state_next_s = FRAME_IDLE;
                end else begin
                    state_next_s = FRAME_DRAIN;
                end
            end
            default: state_next_s = FRAME_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pixel_readout_decoder.sv
// Scoreboard bench for pixel_readout_decoder (default parameters).
module tb_pixel_readout_decoder;

    localparam int BD   = 10;
    localparam int PPF  = 4;
    localparam int FD   = 4;

    typedef struct {
        logic [BD-1:0] data;
        int            idx;
        bit            last;
    } exp_t;

    logic          clk;
    logic          readout_reset;
    logic [BD-1:0] gray_data;
    logic          gray_valid;
    logic          gray_ready;
    logic [BD-1:0] pixel_data;
    logic [1:0]    pixel_index;
    logic          pixel_last;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          frame_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   m_idx    = 0;
    bit   m_drain  = 1'b0;
    int   fd_count = 0;
    logic [BD-1:0] cur_bin = '0;
    bit   done_rand;

    pixel_readout_decoder #(
        .BIT_DEPTH        (BD),
        .PIXELS_PER_FRAME (PPF),
        .FIFO_DEPTH       (FD)
    ) dut (
        .readout_clock (clk),
        .readout_reset (readout_reset),
        .gray_data     (gray_data),
        .gray_valid    (gray_valid),
        .gray_ready    (gray_ready),
        .pixel_data    (pixel_data),
        .pixel_index   (pixel_index),
        .pixel_last    (pixel_last),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: the model's occupancy is the queue length, and
    // a frame blocks input from acceptance of its last word until that pop.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_fd;
        if (readout_reset) begin
            chk("frame_done_in_reset", {31'd0, frame_done}, 32'd0);
            q.delete();
            m_idx   = 0;
            m_drain = 1'b0;
        end else begin
            chk("gray_ready", {31'd0, gray_ready},
                {31'd0, (!m_drain && (q.size() < FD))});
            chk("pixel_valid", {31'd0, pixel_valid}, {31'd0, (q.size() != 0)});
            exp_fd = 1'b0;
            if (pixel_valid && (q.size() > 0)) begin
                e = q[0];
                chk("pixel_data", {22'd0, pixel_data}, {22'd0, e.data});
                chk("pixel_index", {30'd0, pixel_index}, e.idx);
                chk("pixel_last", {31'd0, pixel_last}, {31'd0, e.last});
                if (pixel_ready) begin
                    void'(q.pop_front());
                    if (e.last) begin
                        exp_fd  = 1'b1;
                        m_drain = 1'b0;
                    end
                end
            end
            chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
            if (frame_done) fd_count++;
            if (gray_valid && gray_ready) begin
                e.data = cur_bin;
                e.idx  = m_idx;
                e.last = (m_idx == PPF - 1);
                if (e.last) m_drain = 1'b1;
                q.push_back(e);
                m_idx = (m_idx + 1) % PPF;
            end
        end
    end

    // Offer one word (given in binary; the bus carries its gray code) until accepted.
    task automatic send(input logic [BD-1:0] v);
        bit ok = 1'b0;
        cur_bin    = v;
        gray_data  = v ^ (v >> 1);
        gray_valid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (gray_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        gray_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 1000 cycles");
        end
    endtask

    task automatic wait_empty();
        bit ok = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fd_before;
        logic [BD-1:0] w0;
        gray_valid    = 1'b0;
        gray_data     = '0;
        pixel_ready   = 1'b1;
        readout_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        readout_reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, pixel_valid}, 32'd0);
        chk("rst_data", {22'd0, pixel_data}, 32'd0);
        chk("rst_index", {30'd0, pixel_index}, 32'd0);
        chk("rst_last", {31'd0, pixel_last}, 32'd0);
        chk("rst_ready", {31'd0, gray_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Decode sweep over every 10-bit value.
        for (int v = 0; v < 1024; v++) send(BD'(v));
        wait_empty();

        // Backpressure: four words fill the buffer, head holds word 0.
        pixel_ready = 1'b0;
        w0 = BD'($urandom_range(0, 1023));
        send(w0);
        for (int i = 1; i < 4; i++) send(BD'($urandom_range(0, 1023)));
        @(negedge clk);
        chk("bp_ready_low", {31'd0, gray_ready}, 32'd0);
        chk("bp_head_word0", {22'd0, pixel_data}, {22'd0, w0});
        repeat (3) @(posedge clk);
        #1;
        pixel_ready = 1'b1;
        wait_empty();

        // Simultaneous push/pop with two words buffered.
        pixel_ready = 1'b0;
        send(BD'(10'h155));
        send(BD'(10'h2AA));
        pixel_ready = 1'b1;
        send(BD'(10'h0F0));
        send(BD'(10'h30F));
        wait_empty();

        // Reset after two words of a frame.
        pixel_ready = 1'b0;
        fd_before   = fd_count;
        send(BD'(10'h011));
        send(BD'(10'h022));
        readout_reset = 1'b1;
        @(posedge clk);
        #1;
        readout_reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {31'd0, pixel_valid}, 32'd0);
        chk("midrst_no_frame_done", fd_count, fd_before);
        @(posedge clk);
        #1;
        pixel_ready = 1'b1;
        for (int i = 0; i < PPF; i++) send(BD'($urandom_range(0, 1023)));
        wait_empty();

        // Randomized valid/ready over 100 frames.
        fd_count  = 0;
        done_rand = 1'b0;
        fork
            begin
                for (int i = 0; i < 100 * PPF; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(BD'($urandom_range(0, 1023)));
                end
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    @(posedge clk);
                    #1;
                    pixel_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        pixel_ready = 1'b1;
        wait_empty();
        chk("frame_done_count", fd_count, 32'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
